mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Multi-precision add/subtract sequencer that drives the 16-bit carry-select adder. It accepts operands as a stream of 16-bit word pairs, least-significant word first, and presents each pair to the external adder. It chains the adder's carry-out into the next word's carry-in and returns registered sum words with end-of-operand flags. It sits between the operand source and the result consumer and owns all carry state, so the adder itself stays purely combinational.

## Interface
- MAX_WORDS, 8: maximum words per operand (≥2); counter width is clog2(MAX_WORDS+1).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word pair valid.
- in_ready  out  1  sequencer can accept the input word pair.
- in_a  in  16  operand A word.
- in_b  in  16  operand B word.
- in_first  in  1  first (least-significant) word of an operand.
- in_last  in  1  last (most-significant) word of an operand.
- in_sub  in  1  subtract (A−B); sampled only on the first word.
- add_a  out  16  to adder a; driven from stage-1 register.
- add_b  out  16  to adder b; B word, inverted when subtracting.
- add_cin  out  1  to adder cin.
- add_s  in  16  adder sum.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result word.
- out_sum  out  16  result word.
- out_last  out  1  final word of the result.
- out_cout  out  1  carry-out of the word; on a subtraction's last word, 1 = no borrow.
- out_ovf  out  1  signed overflow; meaningful only when out_last=1, else 0.
- out_err  out  1  protocol error associated with this word.

## Operation
- Two register stages:
  - S1 holds the operand word, sub, first, last and err.
  - The adder sits combinationally between S1 and S2.
  - S2 holds the result word.
- Handshake:
  - Transfer on valid&&ready.
  - in_ready = !rst && (!s1_valid || s2_free), where s2_free = !out_valid || out_ready.
  - S1→S2 moves whenever s1_valid && s2_free.
- Operand presentation:
  - add_a = s1_a.
  - add_b = s1_sub ? ~s1_b : s1_b.
  - add_cin = s1_first ? s1_sub : carry_r.
- Carry register: carry_r is updated to add_cout on each S1→S2 move and is cleared when a last word moves.
- FSM, evaluated at input acceptance:
  - IDLE (expect first word). Accepting a word latches in_sub into op_sub and sets the word counter to 1.
    - in_last=1 → stay in IDLE.
    - Otherwise → MID.
    - in_first=0 in IDLE → word is treated as first, err=1.
  - MID.
    - Accepting a word with in_first=1 → restart: treated as first, new sub latched, err=1, counter reset to 1.
    - Otherwise, counter increments and op_sub is reused.
    - in_last=1, or counter reaching MAX_WORDS → word is marked last; return to IDLE. If the limit was hit without in_last, err=1.
- Overflow on the last word: out_ovf = (add_a[15]==add_b[15]) && (add_s[15]!=add_a[15]).
- Stage S2 captures add_s, add_cout, ovf, last and err on the S1→S2 move.

## Timing
- Reset values:
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, out_err=0.
  - S1 is empty; carry_r=0; FSM in IDLE with counter 0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k+1 when there is no backpressure.
- Throughput is 1 word/cycle.
- Backpressure:
  - With out_ready=0, at most 2 words are buffered (S1 and S2), then in_ready=0.
  - Outputs are held stable while out_valid && !out_ready.
- Simultaneous events: with S2 full and out_ready=1, an S2 pop, an S1→S2 move and a new input accept all happen on the same edge.
- Reset mid-operation discards all in-flight words and the carry; the next word is expected to be a first word.

## Test plan
- Single word: 0x1234 + 0x0FCC, first=last=1, sub=0 → out_sum=0x2200, out_cout=0, out_ovf=0, out_err=0, output 2 edges after accept.
- Two-word carry chain: A=0x0001_FFFF, B=0x0000_0001 → word 0 = 0x0000 with cout=1; word 1 = 0x0002 with last=1 and cout=0.
- Subtract: 0x0005 − 0x0007, single word → out_sum=0xFFFE, out_cout=0 (borrow), out_ovf=0; 0x7FFF + 0x0001 → out_sum=0x8000, out_ovf=1.
- Backpressure: stream 4 words with out_ready=0 for 4 cycles → in_ready falls after 2 accepts, out_sum is held, all 4 words arrive in order with correct carries.
- Protocol errors, MAX_WORDS=4:
  - Send 5 words with no in_last → word 4 has out_last=1, out_err=1; word 5 is treated as first with out_err=1.
  - in_first asserted mid-operand → carry restarts, out_err=1 on that word.
- Reset mid-operand: assert rst after word 1 of 3 → out_valid=0 the next cycle, carry_r=0; a fresh 0x0001 + 0x0001 then gives 0x0002.

Source files
------------

// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: operand stream, external adder and result stream signals of the sequencer
interface mp_add_seq_if;
  logic        in_valid, in_ready, in_first, in_last, in_sub;
  logic [15:0] in_a, in_b;
  logic [15:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready, out_last, out_cout, out_ovf, out_err;
  logic [15:0] out_sum;
  modport master (
    input  in_valid, in_a, in_b, in_first, in_last, in_sub, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );
  modport slave (
    output in_valid, in_a, in_b, in_first, in_last, in_sub, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer chaining carries through an external 16-bit adder
module mp_add_seq #(
  parameter int MAX_WORDS = 8
) (
  input logic         clk,
  input logic         rst,
  mp_add_seq_if.master bus
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  typedef enum logic {IDLE, MID} state_t;
  state_t        state;
  logic [CW-1:0] cnt, ncnt;
  logic [15:0]   s1_a, s1_b;
  logic          s1_valid, s1_sub, s1_first, s1_last, s1_err, op_sub, carry_r;
  logic          s2_free, acc, move, w_first, w_lim, w_last, w_err;
  assign s2_free      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid || s2_free);
  assign acc          = bus.in_valid && bus.in_ready;
  assign move         = s1_valid && s2_free;
  assign bus.add_a    = s1_a;
  assign bus.add_b    = s1_sub ? ~s1_b : s1_b;
  assign bus.add_cin  = s1_first ? s1_sub : carry_r;
  // A word starts a new operand in IDLE or when in_first forces a restart mid-operand
  always_comb begin
    w_first = (state == IDLE) || bus.in_first;
    ncnt    = w_first ? CW'(1) : cnt + CW'(1);
    w_lim   = !w_first && (ncnt == CW'(MAX_WORDS));
    w_last  = bus.in_last || w_lim;
    w_err   = ((state == IDLE) ^ bus.in_first) || (w_lim && !bus.in_last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_sub        <= 1'b0;
      carry_r       <= 1'b0;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_sub        <= 1'b0;
      s1_first      <= 1'b0;
      s1_last       <= 1'b0;
      s1_err        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      if (acc) begin
        state    <= w_last ? IDLE : MID;
        cnt      <= ncnt;
        op_sub   <= w_first ? bus.in_sub : op_sub;
        s1_a     <= bus.in_a;
        s1_b     <= bus.in_b;
        s1_sub   <= w_first ? bus.in_sub : op_sub;
        s1_first <= w_first;
        s1_last  <= w_last;
        s1_err   <= w_err;
      end
      s1_valid <= acc || (s1_valid && !move);
      if (move) begin
        carry_r      <= !s1_last && bus.add_cout;
        bus.out_sum  <= bus.add_s;
        bus.out_cout <= bus.add_cout;
        bus.out_ovf  <= s1_last && (bus.add_a[15] == bus.add_b[15]) && (bus.add_s[15] != bus.add_a[15]);
        bus.out_last <= s1_last;
        bus.out_err  <= s1_err;
      end
      bus.out_valid <= move || (bus.out_valid && !bus.out_ready);
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq with an operand-level arithmetic reference model
module tb_mp_add_seq;
  localparam int MW = 4;
  typedef struct packed {logic [15:0] sum; logic last, cout, ovf, err;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mp_add_seq_if bif();
  mp_add_seq #(.MAX_WORDS(MW)) dut (.clk(clk), .rst(rst), .bus(bif));
  assign {bif.add_cout, bif.add_s} = {1'b0, bif.add_a} + {1'b0, bif.add_b} + 17'(bif.add_cin);
  exp_t        q[$];
  int          checks = 0, passed = 0, accepted = 0, mode = 0;
  bit          inop = 0, bp_done = 0, held_v = 0, r;
  int          idx = 0;
  logic        msub = 0;
  logic [79:0] ma = '0, mb = '0;
  logic [19:0] held;
  exp_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Operand-level model: accumulate the operand as a wide integer and read each word off the full sum
  task automatic model(input logic [15:0] a, b, input logic f, l, s);
    exp_t x;
    logic [79:0] sm;
    logic [15:0] bb;
    bit le;
    x.err = inop ? f : !f;
    if (!inop || f) begin
      idx = 0; ma = '0; mb = '0; msub = s;
    end else idx++;
    bb = msub ? ~b : b;
    ma[16*idx +: 16] = a;
    mb[16*idx +: 16] = bb;
    sm = ma + mb + 80'(msub);
    le = l || idx == MW - 1;
    if (idx == MW - 1 && !l) x.err = 1'b1;
    x.sum  = sm[16*idx +: 16];
    x.cout = sm[16*idx + 16];
    x.last = le;
    x.ovf  = le && (a[15] == bb[15]) && (x.sum[15] != a[15]);
    inop = !le;
    q.push_back(x);
  endtask

  task automatic send(input logic [15:0] a, b, input logic f, l, s);
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      bif.in_valid = 1'b1; bif.in_a = a; bif.in_b = b;
      bif.in_first = f; bif.in_last = l; bif.in_sub = s;
      #1;
      if (bif.in_ready) begin
        model(a, b, f, l, s);
        accepted++;
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bif.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && q.size() != 0; n++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    bif.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom % 3 != 0) : 1'b0;
      bif.out_ready = r;
      if (rst) held_v = 0;
      else begin
        if (held_v) chk("hold", {bif.out_sum, bif.out_last, bif.out_cout, bif.out_ovf, bif.out_err}, held);
        held_v = bif.out_valid && !r;
        held = {bif.out_sum, bif.out_last, bif.out_cout, bif.out_ovf, bif.out_err};
        if (bif.out_valid && r) begin
          if (q.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            e = q.pop_front();
            chk("word", {bif.out_sum, bif.out_last, bif.out_cout, bif.out_ovf, bif.out_err}, e);
          end
        end
      end
    end
  end

  initial begin
    bif.in_valid = 0; bif.in_a = 0; bif.in_b = 0; bif.in_first = 0; bif.in_last = 0; bif.in_sub = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", bif.in_ready, 0);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_outputs", {bif.out_sum, bif.out_last, bif.out_cout, bif.out_ovf, bif.out_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", bif.in_ready, 1);
    send(16'h1234, 16'h0FCC, 1, 1, 0);
    chk("lat_edge1", bif.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge2", bif.out_valid, 1);
    chk("single_sum", bif.out_sum, 16'h2200);
    send(16'hFFFF, 16'h0001, 1, 0, 0);
    send(16'h0001, 16'h0000, 0, 1, 0);
    send(16'h0005, 16'h0007, 1, 1, 1);
    send(16'h7FFF, 16'h0001, 1, 1, 0);
    drain();
    mode = 2;
    begin
      int a0;
      a0 = accepted;
      fork
        begin
          send(16'hFFFF, 16'h0001, 1, 0, 0);
          send(16'hFFFF, 16'h0000, 0, 0, 0);
          send(16'hFFFF, 16'h0000, 0, 0, 0);
          send(16'h0001, 16'h0001, 0, 1, 0);
          bp_done = 1;
        end
      join_none
      repeat (6) @(negedge clk);
      #2;
      chk("bp_accepts", accepted - a0, 2);
      chk("bp_in_ready", bif.in_ready, 0);
      mode = 0;
      for (int n = 0; n < 100 && !bp_done; n++) @(negedge clk);
      chk("bp_done", bp_done, 1);
    end
    for (int i = 0; i < 5; i++) send(16'(i * 16'h1111), 16'hF000, i == 0, 0, 0);
    send(16'hFFFF, 16'h0001, 1, 0, 0);
    send(16'h0002, 16'h0003, 0, 1, 0);
    drain();
    mode = 2;
    send(16'hFFFF, 16'h0001, 1, 0, 0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_out_valid", bif.out_valid, 0);
    chk("midrst_in_ready", bif.in_ready, 0);
    q.delete();
    inop = 0;
    rst = 1'b0;
    mode = 0;
    send(16'h0001, 16'h0001, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("after_rst_sum", bif.out_sum, 16'h0002);
    drain();
    mode = 1;
    for (int o = 0; o < 60; o++) begin
      int len;
      logic s;
      len = $urandom_range(1, 5);
      s = $urandom % 2;
      for (int w = 0; w < len; w++)
        send(($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom), ($urandom % 4 == 0) ? 16'h0000 : 16'($urandom),
             (w == 0) ^ ($urandom % 12 == 0), w == len - 1, s);
    end
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
